// File: rtl/morse_encoder_param.sv
// morse_encoder_param: serial Morse encoder for the letters A..Z.
//
// Start with a valid Letter code (0=A .. 25=Z) loads that letter's pattern from an
// internal ROM and shifts it out on DotDashOut, one unit at a time. Each unit lasts
// TICKS_PER_UNIT clock cycles. After the letter, GAP_UNITS low units are sent, and
// then Done pulses for one cycle.
//
// Ports:
//   ClockIn     in   rising-edge clock
//   Resetn      in   synchronous active-low reset
//   Start       in   request, sampled every rising edge
//   Letter      in   letter code, sampled with Start
//   Busy        out  high while a letter or its trailing gap is being sent
//   Done        out  one-cycle pulse when the gap completes
//   Err         out  one-cycle pulse when Start carries an invalid code
//   DotDashOut  out  serial Morse output, 1 = lit
//   NewBitOut   out  one-cycle pulse in the first cycle of every unit
//
// Optional feature: define MORSE_HOLD_EN to add a one-entry pending buffer. A valid
// Start that arrives while Busy is held and launched in the Done cycle.
module morse_encoder_param #(
  parameter int unsigned TICKS_PER_UNIT = 2,
  parameter int unsigned LETTER_W       = 5,
  parameter int unsigned NUM_LETTERS    = 26,
  parameter int unsigned PATTERN_W      = 16,
  parameter int unsigned GAP_UNITS      = 3
) (
  input  logic                ClockIn,
  input  logic                Resetn,
  input  logic                Start,
  input  logic [LETTER_W-1:0] Letter,
  output logic                Busy,
  output logic                Done,
  output logic                Err,
  output logic                DotDashOut,
  output logic                NewBitOut
);

  localparam int unsigned CntW  = $clog2(TICKS_PER_UNIT) + 1;
  localparam int unsigned UnitW = $clog2(PATTERN_W + GAP_UNITS + 1);
  localparam logic [CntW-1:0]  CntMax  = CntW'(TICKS_PER_UNIT - 1);
  localparam logic [UnitW-1:0] GapLoad = UnitW'(GAP_UNITS);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e               state_q, state_d;
  logic [PATTERN_W-1:0] shreg_q, shreg_d;
  logic [UnitW-1:0]     units_q, units_d;  // units left in the current phase
  logic [CntW-1:0]      cnt_q, cnt_d;      // ticks left in the current unit
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [LETTER_W-1:0]  letter_sel;
  logic                 start_ok;          // external Start with an in-range code
  logic [12:0]          rom_raw;           // pattern, right-justified
  logic [3:0]           rom_len;
  logic [PATTERN_W-1:0] rom_pat;           // pattern, left-justified

  assign start_ok = Start && (32'(Letter) < NUM_LETTERS);

`ifdef MORSE_HOLD_EN
  logic                pend_valid_q, pend_valid_d;
  logic [LETTER_W-1:0] pend_letter_q, pend_letter_d;

  // Pending entry can only be valid in IDLE during the Done cycle.
  assign letter_sel = pend_valid_q ? pend_letter_q : Letter;
`else
  assign letter_sel = Letter;
`endif

  // Morse ROM: dot = 1, dash = 111, separator = 0.
  always_comb begin
    rom_raw = '0;
    rom_len = '0;
    case (32'(letter_sel))
      0:  begin rom_raw = 13'b10111;         rom_len = 4'd5;  end // A
      1:  begin rom_raw = 13'b111010101;     rom_len = 4'd9;  end // B
      2:  begin rom_raw = 13'b11101011101;   rom_len = 4'd11; end // C
      3:  begin rom_raw = 13'b1110101;       rom_len = 4'd7;  end // D
      4:  begin rom_raw = 13'b1;             rom_len = 4'd1;  end // E
      5:  begin rom_raw = 13'b101011101;     rom_len = 4'd9;  end // F
      6:  begin rom_raw = 13'b111011101;     rom_len = 4'd9;  end // G
      7:  begin rom_raw = 13'b1010101;       rom_len = 4'd7;  end // H
      8:  begin rom_raw = 13'b101;           rom_len = 4'd3;  end // I
      9:  begin rom_raw = 13'b1011101110111; rom_len = 4'd13; end // J
      10: begin rom_raw = 13'b111010111;     rom_len = 4'd9;  end // K
      11: begin rom_raw = 13'b101110101;     rom_len = 4'd9;  end // L
      12: begin rom_raw = 13'b1110111;       rom_len = 4'd7;  end // M
      13: begin rom_raw = 13'b11101;         rom_len = 4'd5;  end // N
      14: begin rom_raw = 13'b11101110111;   rom_len = 4'd11; end // O
      15: begin rom_raw = 13'b10111011101;   rom_len = 4'd11; end // P
      16: begin rom_raw = 13'b1110111010111; rom_len = 4'd13; end // Q
      17: begin rom_raw = 13'b1011101;       rom_len = 4'd7;  end // R
      18: begin rom_raw = 13'b10101;         rom_len = 4'd5;  end // S
      19: begin rom_raw = 13'b111;           rom_len = 4'd3;  end // T
      20: begin rom_raw = 13'b1010111;       rom_len = 4'd7;  end // U
      21: begin rom_raw = 13'b101010111;     rom_len = 4'd9;  end // V
      22: begin rom_raw = 13'b101110111;     rom_len = 4'd9;  end // W
      23: begin rom_raw = 13'b11101010111;   rom_len = 4'd11; end // X
      24: begin rom_raw = 13'b1110101110111; rom_len = 4'd13; end // Y
      25: begin rom_raw = 13'b11101110101;   rom_len = 4'd11; end // Z
      default: begin rom_raw = '0;           rom_len = 4'd0;  end
    endcase
  end

  assign rom_pat = PATTERN_W'(rom_raw) << (PATTERN_W - 32'(rom_len));

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    units_d = units_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef MORSE_HOLD_EN
    pend_valid_d  = pend_valid_q;
    pend_letter_d = pend_letter_q;
`endif

    unique case (state_q)
      StIdle: begin
`ifdef MORSE_HOLD_EN
        if (pend_valid_q || start_ok) begin
          pend_valid_d = 1'b0;
`else
        if (start_ok) begin
`endif
          shreg_d = rom_pat;
          units_d = UnitW'(rom_len);
          cnt_d   = CntMax;
          state_d = StSend;
        end else if (Start) begin
          err_d = 1'b1;
        end
      end

      StSend: begin
        if (cnt_q == '0) begin
          shreg_d = shreg_q << 1;
          cnt_d   = CntMax;
          if (units_q == UnitW'(1)) begin
            units_d = GapLoad;
            state_d = StGap;
          end else begin
            units_d = units_q - UnitW'(1);
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StGap: begin
        if (cnt_q == '0) begin
          if (units_q == UnitW'(1)) begin
            units_d = '0;
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            units_d = units_q - UnitW'(1);
            cnt_d   = CntMax;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      default: state_d = StIdle;
    endcase

`ifdef MORSE_HOLD_EN
    // Requests arriving mid-letter: queue one valid code, flag invalid ones.
    if (state_q != StIdle && Start) begin
      if (!start_ok) begin
        err_d = 1'b1;
      end else if (!pend_valid_q) begin
        pend_valid_d  = 1'b1;
        pend_letter_d = Letter;
      end
    end
`endif
  end

  always_ff @(posedge ClockIn) begin
    if (!Resetn) begin
      state_q <= StIdle;
      shreg_q <= '0;
      units_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef MORSE_HOLD_EN
      pend_valid_q  <= 1'b0;
      pend_letter_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      units_q <= units_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef MORSE_HOLD_EN
      pend_valid_q  <= pend_valid_d;
      pend_letter_q <= pend_letter_d;
`endif
    end
  end

  // All outputs decode directly from registers.
  assign Busy       = (state_q != StIdle);
  assign DotDashOut = (state_q == StSend) && shreg_q[PATTERN_W-1];
  assign NewBitOut  = (state_q != StIdle) && (cnt_q == CntMax);
  assign Done       = done_q;
  assign Err        = err_q;

endmodule

// File: tb/tb_morse_encoder_param.sv
// Scoreboard bench for morse_encoder_param at TICKS_PER_UNIT = 2.
// Stimulus pushes per-cycle expected output records {Busy,Done,Err,DotDash,NewBit};
// a negedge monitor compares the DUT against the record for the current cycle, or
// against all-zero when no record is queued for that cycle.
module tb_morse_encoder_param;

  localparam int T   = 2;
  localparam int GAP = 3;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic [4:0] letter;
  logic       busy, done, err, dd, nb;

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    int         cyc;
    logic [4:0] v;   // {Busy, Done, Err, DotDashOut, NewBitOut}
  } rec_t;

  rec_t exp_q[$];

  morse_encoder_param #(
    .TICKS_PER_UNIT(T),
    .LETTER_W(5),
    .NUM_LETTERS(26),
    .PATTERN_W(16),
    .GAP_UNITS(GAP)
  ) dut (
    .ClockIn(clk),
    .Resetn(rstn),
    .Start(start),
    .Letter(letter),
    .Busy(busy),
    .Done(done),
    .Err(err),
    .DotDashOut(dd),
    .NewBitOut(nb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk5(input string name, input logic [4:0] act, input logic [4:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got {busy,done,err,dd,nb}=%b, expected %b",
               name, cyc, act, expv);
    end
  endtask

  // Monitor: one comparison per cycle while enabled.
  always @(negedge clk) begin
    rec_t       r;
    logic [4:0] expv;
    if (mon_en) begin
      expv = '0;
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
        r    = exp_q.pop_front();
        expv = r.v;
      end
      chk5("monitor", {busy, done, err, dd, nb}, expv);
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  // Queue expected records for a letter whose units are given as a string of 0/1,
  // starting the cycle after start cycle s. Optionally append the gap and Done.
  task automatic push_letter(input int s, input string u, input bit full, output int done_c);
    rec_t  r;
    int    c;
    string all;
    c   = s + 1;
    all = u;
    if (full) for (int g = 0; g < GAP; g++) all = {all, "0"};
    for (int i = 0; i < all.len(); i++) begin
      for (int t = 0; t < T; t++) begin
        r.cyc = c;
        r.v   = {1'b1, 1'b0, 1'b0, (all[i] == 8'h31), (t == 0)};
        exp_q.push_back(r);
        c++;
      end
    end
    if (full) begin
      r.cyc = c;
      r.v   = 5'b01000;
      exp_q.push_back(r);
    end
    done_c = c;
  endtask

  task automatic run_letter(input int code, input string u);
    int s, d;
    s      = cyc;
    letter = 5'(code);
    start  = 1'b1;
    push_letter(s, u, 1'b1, d);
    step();
    start = 1'b0;
    wait_until(d + 2);
  endtask

  task automatic run_invalid(input int code);
    rec_t r;
    int   s;
    s      = cyc;
    letter = 5'(code);
    start  = 1'b1;
    r.cyc  = s + 1;
    r.v    = 5'b00100;
    exp_q.push_back(r);
    step();
    start = 1'b0;
    step(4);
  endtask

  int    tbl_c[6] = '{0, 1, 16, 19, 24, 25};
  string tbl_s[6] = '{"10111", "111010101", "1110111010111", "111",
                      "1110101110111", "11101110101"};

  initial begin
    int s, d, d2;
    rstn   = 1'b0;
    start  = 1'b0;
    letter = '0;
    step(3);
    chk5("reset_state", {busy, done, err, dd, nb}, 5'b00000);
    rstn   = 1'b1;
    mon_en = 1'b1;
    step(2);

    // E: lit cycles 1-2, gap 3-8, Done at 9.
    run_letter(4, "1");
    // A: 1,1,0,0,1,1,1,1,1,1 then 6 low, Done at 17.
    run_letter(0, "10111");
    // Invalid codes: Err only.
    run_invalid(26);
    run_invalid(31);
    // Table of letters including the last valid code.
    for (int i = 0; i < 6; i++) run_letter(tbl_c[i], tbl_s[i]);

    // T, then E requested while Busy at cycle 3.
    s      = cyc;
    letter = 5'd19;
    start  = 1'b1;
    push_letter(s, "111", 1'b1, d);
`ifdef MORSE_HOLD_EN
    push_letter(d, "1", 1'b1, d2);
`else
    d2 = d;
`endif
    step();
    start = 1'b0;
    step(2);
    letter = 5'd4;
    start  = 1'b1;
    step();
    start = 1'b0;
    wait_until(d2 + 2);

    // Q aborted by reset driven during cycle 10; nothing afterwards.
    s      = cyc;
    letter = 5'd16;
    start  = 1'b1;
    push_letter(s, "11101", 1'b0, d);
    step();
    start = 1'b0;
    wait_until(s + 10);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk5("reset_abort", {busy, done, err, dd, nb}, 5'b00000);
    step(40);
    run_letter(4, "1");

    // S twice, Start held through the first Done cycle.
    s      = cyc;
    letter = 5'd18;
    start  = 1'b1;
    push_letter(s, "10101", 1'b1, d);
    push_letter(d, "10101", 1'b1, d2);
    wait_until(d + 1);
    start = 1'b0;
    wait_until(d2 + 4);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d records left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
